// File: rtl/wash_seq.sv
// Washer program sequencer: runs wash -> rinse -> dry per the phase mask, counting
// time-base ticks, with pause/resume, abort and a timed finish buzzer.
module wash_seq #(
    parameter int unsigned T_WAS  = 3,
    parameter int unsigned T_RIN  = 2,
    parameter int unsigned T_DRY  = 1,
    parameter int unsigned BUZZ_T = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       tr_run,
    input  logic       clr,
    input  logic [2:0] mode,
    input  logic [5:0] u_wat,
    output logic       busy,
    output logic       paused,
    output logic [2:0] ph_drw,
    output logic [5:0] u_cur,
    output logic [5:0] u_tot,
    output logic       fin,
    output logic       buzz
);

    localparam int unsigned CW = 6;
    localparam int unsigned BW = (BUZZ_T > 1) ? $clog2(BUZZ_T) : 1;

    if (5 * (T_WAS + T_RIN + T_DRY) > 63 || BUZZ_T < 1) begin : g_param_chk
        $error("wash_seq: phase times overflow 6-bit counters or BUZZ_T is zero");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WASH  = 3'd1,
        S_RINSE = 3'd2,
        S_DRY   = 3'd3,
        S_FIN   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      w_q, w_nxt, w_in;
    logic [2:0]      mode_q, mode_nxt;
    logic [BW-1:0]   bz_cnt, bz_cnt_nxt;
    logic            paused_nxt, busy_nxt, fin_nxt, buzz_nxt;
    logic [2:0]      ph_nxt;
    logic [CW-1:0]   u_cur_nxt, u_tot_nxt;

    function automatic logic [CW-1:0] phase_len(input state_t s, input logic [2:0] w);
        case (s)
            S_WASH:  return CW'(32'(w) * T_WAS);
            S_RINSE: return CW'(32'(w) * T_RIN);
            S_DRY:   return CW'(32'(w) * T_DRY);
            default: return CW'(0);
        endcase
    endfunction

    function automatic state_t first_phase(input logic [2:0] m);
        if (m[0])      return S_WASH;
        else if (m[1]) return S_RINSE;
        else if (m[2]) return S_DRY;
        else           return S_IDLE;
    endfunction

    // Next enabled phase after s, or FIN when none remain.
    function automatic state_t next_phase(input state_t s, input logic [2:0] m);
        case (s)
            S_WASH:  return m[1] ? S_RINSE : (m[2] ? S_DRY : S_FIN);
            S_RINSE: return m[2] ? S_DRY : S_FIN;
            default: return S_FIN;
        endcase
    endfunction

    assign w_in = (u_wat < 6'd2) ? 3'd2 : ((u_wat > 6'd5) ? 3'd5 : u_wat[2:0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            w_q    <= '0;
            mode_q <= '0;
            bz_cnt <= '0;
            paused <= 1'b0;
            busy   <= 1'b0;
            ph_drw <= '0;
            u_cur  <= '0;
            u_tot  <= '0;
            fin    <= 1'b0;
            buzz   <= 1'b0;
        end else begin
            state  <= state_nxt;
            w_q    <= w_nxt;
            mode_q <= mode_nxt;
            bz_cnt <= bz_cnt_nxt;
            paused <= paused_nxt;
            busy   <= busy_nxt;
            ph_drw <= ph_nxt;
            u_cur  <= u_cur_nxt;
            u_tot  <= u_tot_nxt;
            fin    <= fin_nxt;
            buzz   <= buzz_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        w_nxt      = w_q;
        mode_nxt   = mode_q;
        bz_cnt_nxt = bz_cnt;
        paused_nxt = paused;
        u_cur_nxt  = u_cur;
        u_tot_nxt  = u_tot;
        fin_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (tr_run && mode != 3'b000) begin
                    w_nxt      = w_in;
                    mode_nxt   = mode;
                    paused_nxt = 1'b0;
                    state_nxt  = first_phase(mode);
                    u_cur_nxt  = phase_len(first_phase(mode), w_in);
                    u_tot_nxt  = (mode[0] ? phase_len(S_WASH, w_in)  : CW'(0))
                               + (mode[1] ? phase_len(S_RINSE, w_in) : CW'(0))
                               + (mode[2] ? phase_len(S_DRY, w_in)   : CW'(0));
                end
            end
            S_WASH, S_RINSE, S_DRY: begin
                if (tr_run) paused_nxt = !paused;
                // A simultaneous tick uses the pause flag from before this edge.
                if (tick && !paused) begin
                    if (u_tot != CW'(0)) u_tot_nxt = u_tot - CW'(1);
                    if (u_cur == CW'(1)) begin
                        state_nxt = next_phase(state, mode_q);
                        if (next_phase(state, mode_q) == S_FIN) begin
                            u_cur_nxt  = '0;
                            u_tot_nxt  = '0;
                            paused_nxt = 1'b0;
                            bz_cnt_nxt = '0;
                            fin_nxt    = 1'b1;
                        end else begin
                            u_cur_nxt = phase_len(next_phase(state, mode_q), w_q);
                        end
                    end else if (u_cur != CW'(0)) begin
                        u_cur_nxt = u_cur - CW'(1);
                    end
                end
            end
            S_FIN: begin
                if (tr_run) begin
                    state_nxt  = S_IDLE;
                    bz_cnt_nxt = '0;
                end else if (tick) begin
                    if (bz_cnt == BW'(BUZZ_T - 1)) begin
                        state_nxt  = S_IDLE;
                        bz_cnt_nxt = '0;
                    end else begin
                        bz_cnt_nxt = bz_cnt + BW'(1);
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (clr) begin
            state_nxt  = S_IDLE;
            paused_nxt = 1'b0;
            u_cur_nxt  = '0;
            u_tot_nxt  = '0;
            bz_cnt_nxt = '0;
            fin_nxt    = 1'b0;
        end

        busy_nxt = (state_nxt == S_WASH) || (state_nxt == S_RINSE) || (state_nxt == S_DRY);
        buzz_nxt = (state_nxt == S_FIN);
        ph_nxt   = {state_nxt == S_DRY, state_nxt == S_RINSE, state_nxt == S_WASH};
    end

endmodule

// File: tb/tb_wash_seq.sv
// Scoreboard bench for wash_seq: directed scenarios plus random stimulus checked
// against a program-timeline reference model.
module tb_wash_seq;
    localparam int unsigned T_WAS  = 3;
    localparam int unsigned T_RIN  = 2;
    localparam int unsigned T_DRY  = 1;
    localparam int unsigned BUZZ_T = 4;

    logic       clk = 1'b0;
    logic       rst_n, tick, tr_run, clr;
    logic [2:0] mode;
    logic [5:0] u_wat;
    logic       busy, paused, fin, buzz;
    logic [2:0] ph_drw;
    logic [5:0] u_cur, u_tot;

    wash_seq #(.T_WAS(T_WAS), .T_RIN(T_RIN), .T_DRY(T_DRY), .BUZZ_T(BUZZ_T)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .tr_run(tr_run), .clr(clr),
        .mode(mode), .u_wat(u_wat), .busy(busy), .paused(paused), .ph_drw(ph_drw),
        .u_cur(u_cur), .u_tot(u_tot), .fin(fin), .buzz(buzz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       paused;
        logic [2:0] ph;
        logic [5:0] ucur;
        logic [5:0] utot;
        logic       fin;
        logic       buzz;
    } obs_t;

    obs_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: 0 idle, 1 running, 2 finished; progress tracked as ticks elapsed in program.
    int m_st = 0, m_el = 0, m_tot = 0, m_bz = 0;
    int m_len[3] = '{0, 0, 0};
    bit m_paused = 0, m_finp = 0;

    function automatic void model_step(bit r, bit c, bit t, bit k, bit [2:0] m, bit [5:0] w);
        int wc;
        bit old;
        m_finp = 0;
        if (!r || c) begin
            m_st = 0; m_paused = 0; m_el = 0; m_tot = 0; m_bz = 0;
            return;
        end
        case (m_st)
            0: if (t && m != 3'b000) begin
                wc = (w < 2) ? 2 : ((w > 5) ? 5 : int'(w));
                m_len[0] = m[0] ? wc * T_WAS : 0;
                m_len[1] = m[1] ? wc * T_RIN : 0;
                m_len[2] = m[2] ? wc * T_DRY : 0;
                m_tot = m_len[0] + m_len[1] + m_len[2];
                m_el = 0; m_paused = 0; m_st = 1;
            end
            1: begin
                old = m_paused;
                if (t) m_paused = !m_paused;
                if (k && !old) begin
                    m_el++;
                    if (m_el == m_tot) begin
                        m_st = 2; m_bz = 0; m_paused = 0; m_finp = 1;
                    end
                end
            end
            default: if (t) m_st = 0;
                     else if (k) begin
                         m_bz++;
                         if (m_bz == BUZZ_T) m_st = 0;
                     end
        endcase
    endfunction

    function automatic obs_t model_obs();
        obs_t o = '0;
        int cum = 0;
        bit found = 0;
        if (m_st == 1) begin
            o.busy = 1'b1;
            o.paused = m_paused;
            for (int i = 0; i < 3; i++) begin
                if (!found && m_len[i] > 0 && m_el < cum + m_len[i]) begin
                    o.ph = 3'(1 << i);
                    o.ucur = 6'(cum + m_len[i] - m_el);
                    found = 1;
                end
                cum += m_len[i];
            end
            o.utot = 6'(m_tot - m_el);
        end else if (m_st == 2) begin
            o.buzz = 1'b1;
            o.fin = m_finp;
        end
        return o;
    endfunction

    task automatic step(bit r, bit c, bit t, bit k, bit [2:0] m, bit [5:0] w);
        rst_n = r; clr = c; tr_run = t; tick = k; mode = m; u_wat = w;
        model_step(r, c, t, k, m, w);
        q.push_back(model_obs());
        @(negedge clk);
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 1, 3'b000, 6'd0);
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Monitor: pops one expectation per clock once the stimulus has issued it.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                a = '{busy, paused, ph_drw, u_cur, u_tot, fin, buzz};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL sb@%0t: got b%b p%b ph%b cur%0d tot%0d f%b z%b expected b%b p%b ph%b cur%0d tot%0d f%b z%b",
                             $time, a.busy, a.paused, a.ph, a.ucur, a.utot, a.fin, a.buzz,
                             e.busy, e.paused, e.ph, e.ucur, e.utot, e.fin, e.buzz);
                end
            end
        end
    end

    initial begin
        rst_n = 0; clr = 0; tr_run = 0; tick = 0; mode = 0; u_wat = 0;
        @(negedge clk);
        step(0, 0, 0, 0, 3'b000, 6'd0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ucur", 32'(u_cur), 0);

        // Full program at level 3.
        step(1, 0, 1, 0, 3'b111, 6'd3);
        chk("s1_ph", 32'(ph_drw), 1); chk("s1_cur", 32'(u_cur), 9); chk("s1_tot", 32'(u_tot), 18);
        ticks(9);
        chk("s1_rinse_ph", 32'(ph_drw), 2); chk("s1_rinse_cur", 32'(u_cur), 6);
        chk("s1_rinse_tot", 32'(u_tot), 9);
        ticks(6);
        chk("s1_dry_ph", 32'(ph_drw), 4); chk("s1_dry_cur", 32'(u_cur), 3);
        ticks(3);
        chk("s1_fin", 32'(fin), 1); chk("s1_buzz", 32'(buzz), 1); chk("s1_fin_busy", 32'(busy), 0);
        ticks(3);
        chk("s1_buzz_hold", 32'(buzz), 1);
        ticks(1);
        chk("s1_idle_buzz", 32'(buzz), 0);

        // Rinse only, acknowledged in FIN.
        step(1, 0, 1, 0, 3'b010, 6'd2);
        chk("s2_ph", 32'(ph_drw), 2); chk("s2_cur", 32'(u_cur), 4); chk("s2_tot", 32'(u_tot), 4);
        ticks(4);
        chk("s2_buzz", 32'(buzz), 1);
        step(1, 0, 1, 0, 3'b111, 6'd3);
        chk("s2_ack_buzz", 32'(buzz), 0); chk("s2_ack_busy", 32'(busy), 0);

        // Pause and resume.
        step(1, 0, 1, 0, 3'b111, 6'd3);
        ticks(2);
        step(1, 0, 1, 0, 3'b000, 6'd0);
        chk("s3_paused", 32'(paused), 1); chk("s3_cur", 32'(u_cur), 7);
        ticks(5);
        chk("s3_hold_cur", 32'(u_cur), 7); chk("s3_hold_tot", 32'(u_tot), 16);
        chk("s3_hold_ph", 32'(ph_drw), 1);
        step(1, 0, 1, 0, 3'b000, 6'd0);
        ticks(1);
        chk("s3_resume_cur", 32'(u_cur), 6);

        // tr_run and tick together.
        step(1, 0, 1, 1, 3'b000, 6'd0);
        chk("s4_cur", 32'(u_cur), 5); chk("s4_paused", 32'(paused), 1);
        step(1, 0, 1, 1, 3'b000, 6'd0);
        chk("s4_cur2", 32'(u_cur), 5); chk("s4_paused2", 32'(paused), 0);
        step(1, 1, 0, 0, 3'b000, 6'd0);

        // Water-level clamp and empty mask.
        step(1, 0, 1, 0, 3'b001, 6'd7);
        chk("s5_hi", 32'(u_cur), 15);
        step(1, 1, 0, 0, 3'b000, 6'd0);
        step(1, 0, 1, 0, 3'b001, 6'd0);
        chk("s5_lo", 32'(u_cur), 6);
        step(1, 1, 0, 0, 3'b000, 6'd0);
        step(1, 0, 1, 0, 3'b000, 6'd4);
        chk("s5_empty", 32'(busy), 0);

        // Abort mid-rinse and reset mid-dry, each with a tick.
        step(1, 0, 1, 0, 3'b111, 6'd2);
        ticks(7);
        chk("s6_rinse", 32'(ph_drw), 2);
        step(1, 1, 0, 1, 3'b000, 6'd0);
        chk("s6_clr_ph", 32'(ph_drw), 0); chk("s6_clr_tot", 32'(u_tot), 0);
        step(1, 0, 1, 0, 3'b111, 6'd2);
        ticks(11);
        chk("s6_dry", 32'(ph_drw), 4);
        step(0, 0, 0, 1, 3'b000, 6'd0);
        chk("s6_rst_ph", 32'(ph_drw), 0); chk("s6_rst_busy", 32'(busy), 0);

        for (int i = 0; i < 4000; i++)
            step($urandom_range(999) != 0, $urandom_range(199) == 0, $urandom_range(19) == 0,
                 $urandom_range(9) < 4, 3'($urandom), 6'($urandom));

        step(1, 1, 0, 0, 3'b000, 6'd0);
        @(negedge clk);
        chk("sb_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
